// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

    // Sequencer phases. RUN is the only state in which busy is low.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT    = 3'd4
    } state_e;

    // Width of the shared hold/timeout counter: wide enough for the larger limit.
    function automatic int cnt_width(input int hold_cyc, input int timeout_cyc);
        int m;
        m = (hold_cyc > timeout_cyc) ? hold_cyc : timeout_cyc;
        return $clog2(m) + 1;
    endfunction

    // Width of the domain index, never narrower than one bit.
    function automatic int idx_width(input int num_dom);
        return (num_dom > 1) ? $clog2(num_dom) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable up-counter with clear, enable and a terminal-compare flag.
// Shared by the hold phase and the per-domain ready timeout.
module rst_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_at_term
);

    logic [W-1:0] r_cnt;

    // Count register: clear has priority over load, load over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts NUM_DOM reset domains from the highest index down,
// holds them, then releases them from index 0 up, waiting on each domain's
// ready (with timeout). Runs automatically after rst as the power-on release.
//
// Handshake: domain_ready[i] is a level, not a pulse. After domain_rst[i]
// falls, the sequencer samples domain_ready[i] every cycle it is waiting on
// domain i and advances on the first cycle it is seen high; ready bits of
// domains not currently being waited on are ignored.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = 4,
    parameter int HOLD_CYC    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] domain_ready,
    output logic [NUM_DOM-1:0] domain_rst,
    output logic               busy,
    output logic               done,
    output logic [NUM_DOM-1:0] err_dom
);

    localparam int CNT_W = cnt_width(HOLD_CYC, TIMEOUT_CYC);
    localparam int IDX_W = idx_width(NUM_DOM);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOM - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    // Every sequencer register except the shared counter; state is visible
    // here for checkers bound to r_q.state.
    typedef struct packed {
        state_e             state;
        logic [NUM_DOM-1:0] domain_rst;
        logic               busy;
        logic               done;
        logic [NUM_DOM-1:0] err_dom;
        logic [IDX_W-1:0]   idx;
        logic               pending;
        logic               sw_q;
    } regs_t;

    regs_t            r_q;
    regs_t            w_d;
    logic             w_rise;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_at_term;
    logic             w_adv;
    logic [CNT_W-1:0] w_cnt_term;

    assign w_rise     = sw_rst_req & ~r_q.sw_q;
    assign w_cnt_term = (r_q.state == ST_WAIT) ? TIMEOUT_TERM : HOLD_TERM;

    rst_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_load     (1'b0),
        .i_load_val ({CNT_W{1'b0}}),
        .i_en       (w_cnt_en),
        .i_term     (w_cnt_term),
        .o_at_term  (w_at_term)
    );

    // State register: reset lands in HOLD with all domains in reset, which
    // makes the power-on release fall out of the normal sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q.state      <= ST_HOLD;
            r_q.domain_rst <= '1;
            r_q.busy       <= 1'b1;
            r_q.done       <= 1'b0;
            r_q.err_dom    <= '0;
            r_q.idx        <= '0;
            r_q.pending    <= 1'b0;
            r_q.sw_q       <= 1'b0;
        end else begin
            r_q <= w_d;
        end
    end

    // Next-state logic: sequence phases, counter control and sticky flags.
    always_comb begin
        w_d       = r_q;
        w_d.done  = 1'b0;
        w_d.sw_q  = sw_rst_req;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        w_adv     = 1'b0;

        // A request arriving mid-sequence is remembered and replayed from RUN.
        if (w_rise && (r_q.state != ST_RUN)) begin
            w_d.pending = 1'b1;
        end

        case (r_q.state)
            ST_RUN: begin
                w_d.domain_rst = '0;
                if (w_rise || r_q.pending) begin
                    w_d.err_dom = '0;
                    w_d.pending = 1'b0;
                    w_d.idx     = LAST_IDX;
                    w_d.state   = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                w_d.domain_rst[r_q.idx] = 1'b1;
                if (r_q.idx == '0) begin
                    w_cnt_clr = 1'b1;
                    w_d.state = ST_HOLD;
                end else begin
                    w_d.idx = r_q.idx - IDX_W'(1);
                end
            end
            ST_HOLD: begin
                // The counter saturates at the hold limit; a held request
                // keeps every domain in reset indefinitely.
                if (w_at_term && !sw_rst_req) begin
                    w_d.idx   = '0;
                    w_d.state = ST_RELEASE;
                end else if (!w_at_term) begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_RELEASE: begin
                w_d.domain_rst[r_q.idx] = 1'b0;
                w_cnt_clr = 1'b1;
                w_d.state = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready wins over a coincident timeout.
                if (domain_ready[r_q.idx]) begin
                    w_adv = 1'b1;
                end else if (w_at_term) begin
                    w_d.err_dom[r_q.idx] = 1'b1;
                    w_adv = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
                if (w_adv) begin
                    if (r_q.idx == LAST_IDX) begin
                        w_d.state = ST_RUN;
                        w_d.done  = 1'b1;
                    end else begin
                        w_d.idx   = r_q.idx + IDX_W'(1);
                        w_d.state = ST_RELEASE;
                    end
                end
            end
            default: begin
                w_d.domain_rst = '1;
                w_d.state      = ST_HOLD;
            end
        endcase

        w_d.busy = (w_d.state != ST_RUN);
    end

    // Outputs come straight from registers.
    always_comb begin
        domain_rst = r_q.domain_rst;
        busy       = r_q.busy;
        done       = r_q.done;
        err_dom    = r_q.err_dom;
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl with NUM_DOM=4, HOLD_CYC=4, TIMEOUT_CYC=8.
module tb_rst_seq_ctrl;

  localparam int ND = 4;
  localparam int HC = 4;
  localparam int TC = 8;
  localparam int EW = 2 * ND + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_rst_req = 1'b0;
  logic [ND-1:0] domain_ready;
  logic [ND-1:0] domain_rst;
  logic busy;
  logic done;
  logic [ND-1:0] err_dom;

  int tests = 0;
  int fails = 0;

  // Expected per-cycle {domain_rst, busy, done, err_dom}, and observed values.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  // Domain model: domain i reports ready lat[i] cycles after its reset drops.
  int lat[ND];
  int low_cnt[ND];
  bit ready_tie = 1'b0;
  int wait_start[ND];
  int wait_len[ND];

  rst_seq_ctrl #(
    .NUM_DOM     (ND),
    .HOLD_CYC    (HC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst_req   (sw_rst_req),
    .domain_ready (domain_ready),
    .domain_rst   (domain_rst),
    .busy         (busy),
    .done         (done),
    .err_dom      (err_dom)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (domain_rst[i] !== 1'b0) low_cnt[i] <= 0;
      else if (low_cnt[i] < 1000) low_cnt[i] <= low_cnt[i] + 1;
    end
  end

  always_comb begin
    domain_ready = '0;
    for (int i = 0; i < ND; i++)
      domain_ready[i] = ready_tie | ((domain_rst[i] === 1'b0) && (low_cnt[i] >= lat[i]));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ND-1:0] d, input logic b, input logic dn, input logic [ND-1:0] e);
    exp_q.push_back({d, b, dn, e});
  endtask

  // Reference: one whole sequence from the spec's rules, starting at the
  // first ASSERT cycle (or the first HOLD cycle when with_assert is 0) and
  // ending with the RUN cycle that carries the done pulse.
  task automatic push_seq(input bit with_assert, input int hold_len);
    logic [ND-1:0] d;
    logic [ND-1:0] e;
    int nw;
    e = '0;
    if (with_assert)
      for (int k = 0; k < ND; k++) begin
        d = ND'(((1 << k) - 1) << (ND - k));
        push(d, 1'b1, 1'b0, e);
      end
    for (int h = 0; h < hold_len; h++) push('1, 1'b1, 1'b0, e);
    d = '1;
    for (int i = 0; i < ND; i++) begin
      push(d, 1'b1, 1'b0, e);
      d[i] = 1'b0;
      nw = (lat[i] < TC) ? lat[i] + 1 : TC;
      wait_start[i] = exp_q.size();
      wait_len[i] = nw;
      for (int w = 0; w < nw; w++) push(d, 1'b1, 1'b0, e);
      if (lat[i] >= TC) e[i] = 1'b1;
    end
    push('0, 1'b0, 1'b1, e);
  endtask

  // Drive n cycles, recording outputs; sw high for the first sw_hi cycles
  // and for cycle pulse_at.
  task automatic run_trace(input int n, input int sw_hi, input int pulse_at);
    for (int c = 0; c < n; c++) begin
      sw_rst_req = (c < sw_hi) || (c == pulse_at);
      obs_q.push_back({domain_rst, busy, done, err_dom});
      step();
    end
    sw_rst_req = 1'b0;
  endtask

  // One-cycle request from an idle RUN cycle; the sequence begins next cycle.
  task automatic kick(input int hi_cycles);
    sw_rst_req = 1'b1;
    step();
    if (hi_cycles <= 1) sw_rst_req = 1'b0;
  endtask

  task automatic rand_lat(input int maxl);
    for (int i = 0; i < ND; i++) lat[i] = $urandom_range(0, maxl);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] e;
    e = {{ND{1'b1}}, 1'b1, 1'b0, {ND{1'b0}}};
    rst = 1'b1;
    step();
    step();
    tests++;
    if ({domain_rst, busy, done, err_dom} !== e) begin
      fails++;
      $display("FAIL reset_values: got %b, expected %b", {domain_rst, busy, done, err_dom}, e);
    end
  endtask

  task automatic test_power_on();
    int n;
    ready_tie = 1'b1;
    for (int i = 0; i < ND; i++) lat[i] = 0;
    rst = 1'b0;
    push_seq(1'b0, HC);
    n = exp_q.size();
    run_trace(n, 0, -1);
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL power_on[%0d]: got %b, expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL power_on_idle: got busy=%b done=%b, expected busy=0 done=0", busy, done);
    end
    ready_tie = 1'b0;
  endtask

  task automatic test_sw_pulse();
    int n;
    for (int it = 0; it < 3; it++) begin
      rand_lat(3);
      push_seq(1'b1, HC);
      n = exp_q.size();
      kick(1);
      run_trace(n, 0, -1);
      for (int i = 0; i < n; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL sw_pulse[%0d.%0d]: got %b, expected %b", it, i, obs_q[i], exp_q[i]);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_sw_hold();
    int n;
    int h;
    for (int it = 0; it < 4; it++) begin
      h = (it == 0) ? 20 : $urandom_range(1, 30);
      rand_lat(2);
      push_seq(1'b1, (h - ND > HC) ? h - ND : HC);
      n = exp_q.size();
      kick(h);
      run_trace(n, h - 1, -1);
      for (int i = 0; i < n; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL sw_hold[h=%0d,%0d]: got %b, expected %b", h, i, obs_q[i], exp_q[i]);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    rand_lat(2);
    lat[2] = 255;
    push_seq(1'b1, HC);
    n = exp_q.size();
    kick(1);
    run_trace(n, 0, -1);
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL timeout[%0d]: got %b, expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    tests++;
    if (err_dom !== 4'b0100) begin
      fails++;
      $display("FAIL timeout_err_dom: got %b, expected 0100", err_dom);
    end
  endtask

  task automatic test_pending();
    int n;
    int p;
    for (int it = 0; it < 3; it++) begin
      rand_lat(3);
      push_seq(1'b1, HC);
      p = wait_start[1] + $urandom_range(0, wait_len[1] - 1);
      push_seq(1'b1, HC);
      n = exp_q.size();
      kick(1);
      run_trace(n, 0, p);
      for (int i = 0; i < n; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL pending[%0d.%0d]: got %b, expected %b", it, i, obs_q[i], exp_q[i]);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_rst_mid();
    int n;
    logic [EW-1:0] e;
    e = {{ND{1'b1}}, 1'b1, 1'b0, {ND{1'b0}}};
    rand_lat(3);
    push_seq(1'b1, HC);
    n = ND + 2;
    kick(1);
    run_trace(n, 0, -1);
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rst_mid_pre[%0d]: got %b, expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      tests++;
      if ({domain_rst, busy, done, err_dom} !== e) begin
        fails++;
        $display("FAIL rst_mid_reset[%0d]: got %b, expected %b", k, {domain_rst, busy, done, err_dom}, e);
      end
    end
    rst = 1'b0;
    push_seq(1'b0, HC);
    n = exp_q.size();
    run_trace(n, 0, -1);
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rst_mid_post[%0d]: got %b, expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coincident();
    int n;
    logic [EW-1:0] e;
    e = {{ND{1'b1}}, 1'b1, 1'b0, {ND{1'b0}}};
    for (int i = 0; i < ND; i++) lat[i] = 0;
    lat[0] = TC - 1;
    push_seq(1'b1, HC);
    n = exp_q.size();
    kick(1);
    run_trace(n, 0, -1);
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL coincident[%0d]: got %b, expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    tests++;
    if (err_dom !== 4'b0000) begin
      fails++;
      $display("FAIL coincident_err_dom: got %b, expected 0000", err_dom);
    end
    rst = 1'b1;
    step();
    tests++;
    if ({domain_rst, busy, done, err_dom} !== e) begin
      fails++;
      $display("FAIL coincident_reset: got %b, expected %b", {domain_rst, busy, done, err_dom}, e);
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_power_on();
    test_sw_pulse();
    test_sw_hold();
    test_timeout();
    test_pending();
    test_rst_mid();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
